// File: rtl/instr_mem_if.sv
// Instruction-fetch bus (req/gnt/rvalid/rdata) between the fetch stage and its memory.
// The master is the fetch stage; the slave is the instruction memory responder.
interface instr_mem_if;
  logic        instr_req_in;
  logic [31:0] instr_addr_in;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rinstr_o;
  logic        instr_err_o;

  modport master (
    output instr_req_in,
    output instr_addr_in,
    input  instr_gnt_o,
    input  instr_rvalid_o,
    input  instr_rinstr_o,
    input  instr_err_o
  );

  modport slave (
    input  instr_req_in,
    input  instr_addr_in,
    output instr_gnt_o,
    output instr_rvalid_o,
    output instr_rinstr_o,
    output instr_err_o
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: grants fetches, returns words in order after LATENCY
// cycles, bounds outstanding requests, optionally injects grant stalls, and has a preload port.
module instr_mem_responder #(
  parameter int DEPTH_WORDS     = 8192,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int GNT_STALL_EVERY = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  instr_mem_if.slave                     bus,
  input  logic                           load_we_in,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_in,
  input  logic [31:0]                    load_data_in
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_O = CW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic [31:0]   mem [DEPTH_WORDS];
  resp_t         pipe_q [LATENCY];
  logic [CW-1:0] outstanding_q;
  logic          stall_slot;
  logic          accept;
  logic          launch;
  logic          addr_err;
  logic [AW-1:0] word_idx;

  // Grant-stall slot generator; absent entirely when no stalls are requested.
  generate
    if (GNT_STALL_EVERY > 0) begin : g_stall
      localparam int SW = (GNT_STALL_EVERY > 1) ? $clog2(GNT_STALL_EVERY) : 1;
      localparam logic [SW-1:0] LAST = SW'(GNT_STALL_EVERY - 1);
      logic [SW-1:0] stall_cnt_q;

      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stall_cnt_q <= '0;
        end else if (stall_cnt_q == LAST) begin
          stall_cnt_q <= '0;
        end else begin
          stall_cnt_q <= stall_cnt_q + SW'(1);
        end
      end

      assign stall_slot = (stall_cnt_q == LAST);
    end else begin : g_no_stall
      assign stall_slot = 1'b0;
    end
  endgenerate

  assign bus.instr_gnt_o = bus.instr_req_in & reset & (outstanding_q < MAX_O)
                         & ~stall_slot & ~load_we_in;
  assign accept          = bus.instr_req_in & bus.instr_gnt_o;

  // Misaligned or beyond-the-store addresses answer with an error and a zero word.
  assign word_idx = bus.instr_addr_in[AW+1:2];
  assign addr_err = (bus.instr_addr_in[1:0] != 2'b00)
                  | ((bus.instr_addr_in >> (AW + 2)) != 32'd0);

  // NOTE: the instruction store is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (load_we_in) begin
      mem[load_addr_in] <= load_data_in;
    end
  end

  // Data and err only move with a valid token, so the output stage holds its last response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].valid <= accept;
      if (accept) begin
        pipe_q[0].data <= addr_err ? 32'h0000_0000 : mem[word_idx];
        pipe_q[0].err  <= addr_err;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_q[i].valid <= pipe_q[i-1].valid;
        if (pipe_q[i-1].valid) begin
          pipe_q[i].data <= pipe_q[i-1].data;
          pipe_q[i].err  <= pipe_q[i-1].err;
        end
      end
    end
  end

  // A request stops being outstanding at the edge that raises its rvalid.
  generate
    if (LATENCY == 1) begin : g_launch_now
      assign launch = accept;
    end else begin : g_launch_pipe
      assign launch = pipe_q[LATENCY-2].valid;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
    end else if (accept && !launch) begin
      outstanding_q <= outstanding_q + CW'(1);
    end else if (!accept && launch) begin
      outstanding_q <= outstanding_q - CW'(1);
    end
  end

  assign bus.instr_rvalid_o = pipe_q[LATENCY-1].valid;
  assign bus.instr_rinstr_o = pipe_q[LATENCY-1].data;
  assign bus.instr_err_o    = pipe_q[LATENCY-1].err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: three instances cover the default timing,
// a single-outstanding limit and injected grant stalls.
module tb_instr_mem_responder;

  localparam logic [31:0] INSN0  = 32'h0010_0093;
  localparam logic [31:0] INSN1  = 32'h0030_0193;
  localparam logic [31:0] INSN2  = 32'h0020_0113;
  localparam logic [31:0] WORD_A = 32'hDEAD_0003;
  localparam logic [31:0] WORD_B = 32'hBEEF_0003;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_we;
  logic [12:0] load_addr;
  logic [31:0] load_data;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  instr_mem_if bus_a ();
  instr_mem_if bus_b ();
  instr_mem_if bus_c ();

  instr_mem_responder u_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .load_we_in(load_we), .load_addr_in(load_addr), .load_data_in(load_data)
  );

  instr_mem_responder #(.MAX_OUTSTANDING(1)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .load_we_in(load_we), .load_addr_in(load_addr), .load_data_in(load_data)
  );

  instr_mem_responder #(.GNT_STALL_EVERY(4)) u_c (
    .clk(clk), .reset(reset), .bus(bus_c),
    .load_we_in(load_we), .load_addr_in(load_addr), .load_data_in(load_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, 32'(obs), 32'(exp));
  endtask

  // Advance to the next falling edge; callers drive inputs there and settle #1 before checking.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_word(input logic [12:0] idx, input logic [31:0] data);
    load_we   = 1'b1;
    load_addr = idx;
    load_data = data;
    tick();
    load_we   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_q [$];
    int          acc_cnt;
    int          rv_cnt;
    int          inflight;
    logic        g;

    reset     = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    bus_a.instr_req_in = 1'b1; bus_a.instr_addr_in = 32'd0;
    bus_b.instr_req_in = 1'b0; bus_b.instr_addr_in = 32'd0;
    bus_c.instr_req_in = 1'b0; bus_c.instr_addr_in = 32'd0;

    // Reset state: gnt forced low even with a request present.
    tick(); #1;
    check_bit("rst_gnt",    bus_a.instr_gnt_o,    1'b0);
    check_bit("rst_rvalid", bus_a.instr_rvalid_o, 1'b0);
    check    ("rst_rinstr", bus_a.instr_rinstr_o, 32'h0);
    check_bit("rst_err",    bus_a.instr_err_o,    1'b0);
    check_bit("rst_rvalid_b", bus_b.instr_rvalid_o, 1'b0);
    check_bit("rst_rvalid_c", bus_c.instr_rvalid_o, 1'b0);
    bus_a.instr_req_in = 1'b0;

    // Memory is written through the backdoor while still in reset.
    load_word(13'd0, INSN0);
    load_word(13'd1, INSN1);
    load_word(13'd2, INSN2);
    load_word(13'd3, WORD_A);
    for (int k = 16; k < 25; k++) load_word(13'(k), 32'h5A00_0000 + 32'(k));
    reset = 1'b1; #1;

    // 1. Basic fetch: two back-to-back reads, responses two cycles later in order.
    bus_a.instr_req_in = 1'b1; bus_a.instr_addr_in = 32'd0; #1;
    check_bit("t1_gnt0", bus_a.instr_gnt_o, 1'b1);
    tick(); bus_a.instr_addr_in = 32'd4; #1;
    check_bit("t1_gnt1",      bus_a.instr_gnt_o,    1'b1);
    check_bit("t1_rvalid_c1", bus_a.instr_rvalid_o, 1'b0);
    tick(); bus_a.instr_req_in = 1'b0; #1;
    check_bit("t1_rvalid_c2", bus_a.instr_rvalid_o, 1'b1);
    check    ("t1_rinstr_c2", bus_a.instr_rinstr_o, INSN0);
    check_bit("t1_err_c2",    bus_a.instr_err_o,    1'b0);
    tick(); #1;
    check_bit("t1_rvalid_c3", bus_a.instr_rvalid_o, 1'b1);
    check    ("t1_rinstr_c3", bus_a.instr_rinstr_o, INSN1);
    check_bit("t1_err_c3",    bus_a.instr_err_o,    1'b0);
    tick(); #1;
    check_bit("t1_rvalid_c4", bus_a.instr_rvalid_o, 1'b0);

    // 3. Error decode: misaligned and out-of-range both return err with a zero word.
    bus_a.instr_req_in = 1'b1; bus_a.instr_addr_in = 32'h0000_0006; #1;
    check_bit("t3_gnt0", bus_a.instr_gnt_o, 1'b1);
    tick(); bus_a.instr_addr_in = 32'h0001_0000; #1;
    check_bit("t3_gnt1", bus_a.instr_gnt_o, 1'b1);
    tick(); bus_a.instr_req_in = 1'b0; #1;
    check_bit("t3_rvalid_mis", bus_a.instr_rvalid_o, 1'b1);
    check_bit("t3_err_mis",    bus_a.instr_err_o,    1'b1);
    check    ("t3_rinstr_mis", bus_a.instr_rinstr_o, 32'h0);
    tick(); #1;
    check_bit("t3_rvalid_oor", bus_a.instr_rvalid_o, 1'b1);
    check_bit("t3_err_oor",    bus_a.instr_err_o,    1'b1);
    check    ("t3_rinstr_oor", bus_a.instr_rinstr_o, 32'h0);
    tick(); #1;

    // 2. Outstanding limit of one: grant alternates while req is held.
    acc_cnt = 0; rv_cnt = 0;
    bus_b.instr_req_in = 1'b1; bus_b.instr_addr_in = 32'd8; #1;
    for (int i = 0; i < 8; i++) begin
      g = bus_b.instr_gnt_o;
      check_bit("t2_gnt_alt", g, (i % 2) == 0);
      if (bus_b.instr_rvalid_o) begin
        rv_cnt++;
        check("t2_rinstr", bus_b.instr_rinstr_o, INSN2);
      end
      inflight = acc_cnt - rv_cnt;
      check_bit("t2_inflight_le_max", inflight <= 1, 1'b1);
      check_bit("t2_inflight_ge_0",   inflight >= 0, 1'b1);
      if (g) acc_cnt++;
      tick(); #1;
    end
    bus_b.instr_req_in = 1'b0; #1;
    for (int j = 0; j < 3; j++) begin
      if (bus_b.instr_rvalid_o) rv_cnt++;
      tick(); #1;
    end
    check("t2_accepts",   32'(acc_cnt), 32'd4);
    check("t2_responses", 32'(rv_cnt),  32'(acc_cnt));

    // 4. Wait-state injection: gnt low on cycles 3, 7, 11 after reset release.
    reset = 1'b0;
    tick(); reset = 1'b1; #1;
    acc_cnt = 0; rv_cnt = 0;
    bus_c.instr_req_in = 1'b1; bus_c.instr_addr_in = 32'd64; #1;
    for (int i = 0; i < 12; i++) begin
      g = bus_c.instr_gnt_o;
      check_bit("t4_gnt", g, (i % 4) != 3);
      if (bus_c.instr_rvalid_o) begin
        rv_cnt++;
        if (exp_q.size() == 0) check_bit("t4_spurious_rvalid", 1'b1, 1'b0);
        else check("t4_rinstr", bus_c.instr_rinstr_o, exp_q.pop_front());
      end
      if (g) begin
        acc_cnt++;
        exp_q.push_back(32'h5A00_0000 + (bus_c.instr_addr_in >> 2));
      end
      tick();
      if (g) bus_c.instr_addr_in = bus_c.instr_addr_in + 32'd4;
      #1;
    end
    bus_c.instr_req_in = 1'b0; #1;
    for (int j = 0; j < 4; j++) begin
      if (bus_c.instr_rvalid_o) begin
        rv_cnt++;
        if (exp_q.size() == 0) check_bit("t4_spurious_rvalid", 1'b1, 1'b0);
        else check("t4_rinstr", bus_c.instr_rinstr_o, exp_q.pop_front());
      end
      tick(); #1;
    end
    check("t4_accepts",   32'(acc_cnt), 32'd9);
    check("t4_responses", 32'(rv_cnt),  32'd9);

    // 5. Reset mid-flight: two accepted requests are discarded.
    bus_a.instr_req_in = 1'b1; bus_a.instr_addr_in = 32'd0; #1;
    check_bit("t5_gnt0", bus_a.instr_gnt_o, 1'b1);
    tick(); bus_a.instr_addr_in = 32'd4; #1;
    check_bit("t5_gnt1", bus_a.instr_gnt_o, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check_bit("t5_rvalid_in_reset", bus_a.instr_rvalid_o, 1'b0);
    check_bit("t5_gnt_in_reset",    bus_a.instr_gnt_o,    1'b0);
    bus_a.instr_req_in = 1'b0;
    tick(); reset = 1'b1; #1;
    for (int j = 0; j < 3; j++) begin
      check_bit("t5_no_rvalid_after", bus_a.instr_rvalid_o, 1'b0);
      tick(); #1;
    end
    bus_a.instr_req_in = 1'b1; bus_a.instr_addr_in = 32'd0; #1;
    check_bit("t5_regnt0", bus_a.instr_gnt_o, 1'b1);
    tick(); bus_a.instr_addr_in = 32'd4; #1;
    check_bit("t5_regnt1", bus_a.instr_gnt_o, 1'b1);
    tick(); bus_a.instr_req_in = 1'b0; #1;
    check_bit("t5_rvalid0", bus_a.instr_rvalid_o, 1'b1);
    check    ("t5_rinstr0", bus_a.instr_rinstr_o, INSN0);
    tick(); #1;
    check_bit("t5_rvalid1", bus_a.instr_rvalid_o, 1'b1);
    check    ("t5_rinstr1", bus_a.instr_rinstr_o, INSN1);
    tick(); #1;

    // 6. Backdoor write after an accepted read: in-flight read keeps the old word.
    bus_a.instr_req_in = 1'b1; bus_a.instr_addr_in = 32'd12; #1;
    check_bit("t6_gnt_read", bus_a.instr_gnt_o, 1'b1);
    tick();
    load_we = 1'b1; load_addr = 13'd3; load_data = WORD_B; #1;
    check_bit("t6_gnt_during_write", bus_a.instr_gnt_o, 1'b0);
    tick(); load_we = 1'b0; #1;
    check_bit("t6_rvalid_a", bus_a.instr_rvalid_o, 1'b1);
    check    ("t6_rinstr_a", bus_a.instr_rinstr_o, WORD_A);
    check_bit("t6_gnt_reread", bus_a.instr_gnt_o, 1'b1);
    tick(); bus_a.instr_req_in = 1'b0; #1;
    check_bit("t6_rvalid_gap", bus_a.instr_rvalid_o, 1'b0);
    tick(); #1;
    check_bit("t6_rvalid_b", bus_a.instr_rvalid_o, 1'b1);
    check    ("t6_rinstr_b", bus_a.instr_rinstr_o, WORD_B);
    tick(); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
